// File: rtl/gf_pkg.sv
// Shared definitions for the sequential GF(2^m) inverse/multiply unit:
// FSM states, operation codes and the default AES reduction polynomial.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_INV = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam logic [7:0] GF8_AES_POLY = 8'h1B;

  // Holds WIDTH-2 for the largest legal field (m = 16).
  localparam int CNT_W = 5;

endpackage

// File: rtl/gf_inv_seq_if.sv
// Operand/result handshake bundle for gf_inv_seq; out_err exists only when
// GF_INV_ZERO_ERR_EN is defined.
interface gf_inv_seq_if #(
  parameter int WIDTH = 8
);
  // Valid/ready: a transfer happens on a rising edge where valid && ready.
  // The sender holds valid and data stable until that edge; ready may be
  // driven independently of valid, and ready without valid has no effect.
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef GF_INV_ZERO_ERR_EN
  logic             out_err;
`endif

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
`ifdef GF_INV_ZERO_ERR_EN
    , input out_err
`endif
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
`ifdef GF_INV_ZERO_ERR_EN
    , output out_err
`endif
  );

endinterface

// File: rtl/gf_inv_seq_mul.sv
// Combinational GF(2^WIDTH) multiplier, reduction modulo x^WIDTH + POLY,
// evaluated as interleaved shift-reduce-accumulate over the bits of b.
module gf_mul #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1B)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      // sh becomes a * x^(i+1), folded back below degree WIDTH.
      sh = {sh[WIDTH-2:0], 1'b0} ^ (sh[WIDTH-1] ? POLY : '0);
    end
    p = acc;
  end

endmodule

// File: rtl/gf_inv_seq.sv
// Sequential GF(2^WIDTH) inverse (square-and-multiply, a^(2^m-2)) and
// single-cycle multiply on one shared multiplier. Optional GF_INV_ZERO_ERR_EN.
module gf_inv_seq
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF8_AES_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  gf_inv_seq_if.slave  bus,
  output state_t       dbg_state
);

  state_t           state, state_n;
  logic [WIDTH-1:0] r, r_n;
  logic [WIDTH-1:0] a_reg, a_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] mul_x, mul_y, prod;
`ifdef GF_INV_ZERO_ERR_EN
  logic             err, err_n;
`endif

  gf_mul #(.WIDTH(WIDTH), .POLY(POLY)) u_mul (
    .a (mul_x),
    .b (mul_y),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      a_reg <= '0;
      cnt   <= '0;
    end else begin
      r     <= r_n;
      a_reg <= a_n;
      cnt   <= cnt_n;
    end
  end

`ifdef GF_INV_ZERO_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_n;
  end
  assign bus.out_err = err;
`endif

  // Exponent 2^m-2 is (m-1 ones, one zero): r = a covers the leading one,
  // then (SQ, MUL) for each remaining one and a final SQ for the zero.
  always_comb begin
    state_n       = state;
    r_n           = r;
    a_n           = a_reg;
    cnt_n         = cnt;
    mul_x         = r;
    mul_y         = r;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
`ifdef GF_INV_ZERO_ERR_EN
    err_n         = err;
`endif
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_op == OP_MUL) begin
          mul_x = bus.in_a;
          mul_y = bus.in_b;
        end
        if (bus.in_valid) begin
          a_n   = bus.in_a;
          cnt_n = CNT_W'(WIDTH - 2);
`ifdef GF_INV_ZERO_ERR_EN
          err_n = 1'b0;
`endif
          if (bus.in_op == OP_MUL) begin
            r_n     = prod;
            state_n = DONE;
          end
`ifdef GF_INV_ZERO_ERR_EN
          else if (bus.in_a == '0) begin
            r_n     = '0;
            err_n   = 1'b1;
            state_n = DONE;
          end
`endif
          else begin
            r_n     = bus.in_a;
            state_n = SQ;
          end
        end
      end
      SQ: begin
        r_n     = prod;
        state_n = (cnt == '0) ? DONE : MUL;
      end
      MUL: begin
        mul_y   = a_reg;
        r_n     = prod;
        cnt_n   = cnt - 1'b1;
        state_n = SQ;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_n = IDLE;
`ifdef GF_INV_ZERO_ERR_EN
          err_n   = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.out_data = r;
  assign dbg_state    = state;

endmodule
